// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: core status codes,
// active-low gfedcba segment patterns and the digit type.
package calc_pkg;

    localparam logic [1:0] ST_ERRO  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam int N_DIGITS = 8;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;

endpackage

// File: rtl/calc_display_if.sv
// Digit stream from the calculator core: status, BCD data and slot position.
interface calc_display_if
    import calc_pkg::*;
;
    logic [1:0] status;
    digit_t     data;
    logic [3:0] pos;

    modport master (output status, output data, output pos);
    modport slave  (input  status, input  data, input  pos);
endinterface

// File: rtl/seg7_decoder.sv
// BCD digit to active-low gfedcba pattern; non-decimal codes show a dash.
module seg7_decoder
    import calc_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Captures the core's serial digit frame, commits whole frames and scans them
// onto 8 common-anode displays. CALC_DISPLAY_BLANK_EN enables leading-zero blanking.
module calc_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic           clock,
    input  logic           reset,
    calc_display_if.slave  core,
    output logic [7:0]     seg,
    output logic [7:0]     an,
    output logic           frame_done,
    output logic           error
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    digit_t          shadow [N_DIGITS];
    digit_t          active [N_DIGITS];
    logic            wr_seen;
    logic [2:0]      idx;
    logic [CW-1:0]   refresh_cnt;

    logic            is_err;
    logic            capture;
    logic            commit;
    digit_t          cur_digit;
    logic [6:0]      dec_pat;
    logic [6:0]      err_pat;
    logic [6:0]      disp_pat;
    logic            lead_blank;

    // An error cycle drops any write or commit that would otherwise happen in it.
    assign is_err  = (core.status == ST_ERRO);
    assign capture = !error && !is_err && (core.status == ST_BUSY) && !core.pos[3];
    assign commit  = !error && !is_err && core.pos[3] && wr_seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            wr_seen    <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (capture) begin
                shadow[core.pos[2:0]] <= core.data;
                wr_seen               <= 1'b1;
            end
            if (commit) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
                wr_seen <= 1'b0;
            end
            frame_done <= commit;
            if (is_err) begin
                error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            idx         <= idx + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign cur_digit = active[idx];

    seg7_decoder u_dec (
        .digit   (cur_digit),
        .pattern (dec_pat)
    );

    always_comb begin
        err_pat = SEG_BLANK;
        case (idx)
            3'd0:    err_pat = SEG_O;
            3'd1:    err_pat = SEG_R;
            3'd2:    err_pat = SEG_R;
            3'd3:    err_pat = SEG_E;
            default: err_pat = SEG_BLANK;
        endcase
    end

`ifdef CALC_DISPLAY_BLANK_EN
    // Blank when no digit at or above the scanned index is nonzero; digit 0 always shows.
    always_comb begin
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if ((3'(j) >= idx) && (active[j] != 4'd0)) begin
                nz = 1'b1;
            end
        end
        lead_blank = (idx != 3'd0) && !nz;
    end
`else
    assign lead_blank = 1'b0;
`endif

    assign disp_pat = error      ? err_pat   :
                      lead_blank ? SEG_BLANK : dec_pat;

    // seg and an come from the same idx in the same register stage, so they never skew.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg <= 8'hFF;
            an  <= 8'hFF;
        end else begin
            seg <= {1'b1, disp_pat};
            an  <= ~(8'd1 << idx);
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display with REFRESH_DIV=4; expectations hand-derived.
module tb_calc_display;
    import calc_pkg::*;

`ifdef CALC_DISPLAY_BLANK_EN
    localparam logic [7:0] Z = 8'hFF;
`else
    localparam logic [7:0] Z = 8'hC0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] seg, an;
    logic       frame_done, error;
    int         checks = 0;
    int         failures = 0;

    calc_display_if core ();

    calc_display #(.REFRESH_DIV(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .core       (core),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_digits(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            core.status = ST_BUSY;
            core.pos    = 4'(i);
            core.data   = d[4*i +: 4];
            tick();
        end
    endtask

    task automatic commit_check(input string tag, input logic exp);
        core.pos = 4'd8;
        tick();
        chk({tag, "_fd"}, {31'd0, frame_done}, {31'd0, exp});
        core.pos    = 4'hF;
        core.status = ST_READY;
        tick();
        chk({tag, "_fd_end"}, {31'd0, frame_done}, 32'd0);
    endtask

    // Finds the start of the next slot showing ea, checks its pattern and hold time.
    task automatic wait_an(input logic [7:0] ea, input logic [7:0] es, input string tag);
        int n = 0;
        int h = 0;
        while (an == ea && n < 80) begin tick(); n++; end
        while (an != ea && n < 80) begin tick(); n++; end
        chk({tag, "_an"}, {24'd0, an}, {24'd0, ea});
        if (an == ea) begin
            chk({tag, "_seg"}, {24'd0, seg}, {24'd0, es});
            while (an == ea && h < 10) begin tick(); h++; end
            chk({tag, "_hold"}, h, 4);
        end
    endtask

    task automatic scan_all(input logic [63:0] e, input string tag);
        for (int i = 0; i < 8; i++) begin
            wait_an(~(8'd1 << i), e[8*i +: 8], $sformatf("%s_d%0d", tag, i));
        end
    endtask

    initial begin
        int fd_cnt;
        core.status = ST_READY;
        core.pos    = 4'd0;
        core.data   = 4'd0;

        #12;
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_err", {31'd0, error}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        chk("rel_an_before", {24'd0, an}, 32'hFF);
        tick();
        chk("first_an", {24'd0, an}, 32'hFE);
        chk("first_seg", {24'd0, seg}, 32'hC0);

        // Frame 1: digits 2,4,0.. -> "42"
        send_digits(8, 32'h0000_0042);
        chk("f1_fd_pre", {31'd0, frame_done}, 32'd0);
        commit_check("f1", 1'b1);
        scan_all({Z, Z, Z, Z, Z, Z, 8'h99, 8'hA4}, "f1");

        // Partial second frame must not reach the display.
        send_digits(4, 32'h0000_9999);
        core.status = ST_READY;
        core.pos    = 4'd3;
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        chk("part_fd_cnt", fd_cnt, 0);
        wait_an(8'hFE, 8'hA4, "part_d0");
        wait_an(8'hFD, 8'h99, "part_d1");

        // Code 11 at pos1 shows a dash.
        send_digits(8, 32'h0000_00B1);
        commit_check("fb", 1'b1);
        scan_all({Z, Z, Z, Z, Z, Z, 8'hBF, 8'hF9}, "fb");

        // Error mid-stream latches the error screen.
        send_digits(3, 32'h0000_0555);
        chk("err_pre", {31'd0, error}, 32'd0);
        core.status = ST_ERRO;
        core.pos    = 4'd3;
        core.data   = 4'd7;
        tick();
        chk("err_set", {31'd0, error}, 32'd1);
        for (int i = 4; i < 8; i++) begin
            core.status = ST_BUSY;
            core.pos    = 4'(i);
            core.data   = 4'd3;
            tick();
        end
        commit_check("err", 1'b0);
        scan_all({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h86, 8'hAF, 8'hAF, 8'hA3}, "err");
        send_digits(8, 32'h1234_5678);
        commit_check("err2", 1'b0);
        chk("err_sticky", {31'd0, error}, 32'd1);

        // Asynchronous reset mid-scan.
        #2;
        reset = 1'b0;
        #1;
        chk("ar_seg", {24'd0, seg}, 32'hFF);
        chk("ar_an", {24'd0, an}, 32'hFF);
        chk("ar_err", {31'd0, error}, 32'd0);
        chk("ar_fd", {31'd0, frame_done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
        chk("ar_first_an", {24'd0, an}, 32'hFE);
        chk("ar_first_seg", {24'd0, seg}, 32'hC0);
        send_digits(8, 32'h0000_0007);
        commit_check("post", 1'b1);
        wait_an(8'hFE, 8'hF8, "post_d0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Downstream consumer of the calculator core's digit stream (status, data, pos).
- Captures the 8 decimal digits the core emits serially into a shadow buffer, then commits a complete frame to an active buffer.
- Time-multiplexes the active buffer onto 8 common-anode seven-segment displays.
- Latches and shows an "Erro" screen when the core reports error.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit; minimum 2.
- N_DIGITS, 8: number of displays and buffer depth; fixed at 8, pos is 4 bits.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- status  input  2  core status: 00 error, 01 busy (digits streaming), 10 ready.
- data  input  4  BCD digit for slot pos; valid only while status=01.
- pos  input  4  digit slot 0..7, least significant first; values 8..15 mean end of frame.
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1.
- an  output  8  anode enables, active-low, one-hot; bit i drives display i.
- frame_done  output  1  one-cycle pulse when a frame is committed.
- error  output  1  sticky error flag.

Behaviour:
- Reset values: seg=8'hFF, an=8'hFF, frame_done=0, error=0; shadow buffer, active buffer, scan index, refresh counter and wr_seen all 0.
- Capture: each cycle with status=01 and pos<8, shadow[pos] <= data and wr_seen <= 1.
- Commit: in a cycle with pos[3]=1 and wr_seen=1:
  - active <= shadow, wr_seen <= 0.
  - frame_done=1 in the following cycle only.
  - pos>=8 with wr_seen=0 does nothing.
- Capture and commit are independent of status=10; ready cycles are ignored.
- Error:
  - Any cycle with status=00 sets error <= 1, sticky until reset.
  - In that cycle a capture write and a commit are both dropped; error wins.
  - While error=1, capture and commit are disabled and frame_done stays 0.
- Scan:
  - refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, scan index increments mod 8, 7 -> 0.
  - an and seg are registered together from the same index so there is no ghosting.
  - Coming out of reset, the first lit digit is index 0, appearing the cycle after reset deasserts.
- Decode (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10..15 show "-" =3F.
  - blank=7F.
- Error screen:
  - index3 'E'=06, index2 'r'=2F, index1 'r'=2F, index0 'o'=23.
  - indices 7..4 blank.
- Latency: a committed frame appears at the next scan slot boundary for each digit. The active buffer changes only on commit, so no partially written frame is ever displayed.
- Reset mid-frame or mid-scan: everything returns to reset values; a partial shadow is discarded.

Optional Feature:
- Macro: CALC_DISPLAY_BLANK_EN.
- Defined: leading-zero blanking. Digit i>0 is blank when active[j]=0 for every j>=i. Digit 0 is never blanked. Blanking is computed from the active buffer only. The error screen is unaffected.
- Undefined: all 8 digits always shown, zeros as 40.

Decomposition:
- Package calc_pkg holds:
  - status encodings ST_ERRO=2'b00, ST_BUSY=2'b01, ST_READY=2'b10;
  - the seven-segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK, SEG_E, SEG_R, SEG_O);
  - typedef digit_t (logic [3:0]).
- Sub-module seg7_decoder: combinational digit_t -> 7-bit pattern, instantiated once on the scan path.

Test Plan:
- Reset pulse mid-scan -> seg=FF, an=FF, error=0, frame_done=0 within the same cycle, asynchronously.
- REFRESH_DIV=4; stream pos0..7 with status=01 and data 2,4,0,0,0,0,0,0, then pos=8 -> frame_done high exactly one cycle later.
- Same frame, continued -> scan shows an=FE/seg=A4 and an=FD/seg=99. an=FB..7F show seg=FF with CALC_DISPLAY_BLANK_EN defined, seg=C0 without. Each an value is held for 4 cycles.
- Second frame started (pos0..3 written) then pos held <8 -> display still shows 42; no frame_done.
- Frame with data=4'hB at pos1 -> digit 1 shows seg=BF.
- status=00 for one cycle during streaming -> error=1 next cycle. Digits 3..0 show 86, AF, AF, A3; upper digits FF. A later valid frame plus pos=8 gives no frame_done and no change, until reset.
